// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the SRAM-slave FSM state enum and the
// little-endian byte-lane decode used for sub-word writes.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle; clock and reset stay outside as plain ports.
interface ahb_sram_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_hsel;
    logic [ADDR_WIDTH-1:0] i_haddr;
    logic [1:0]            i_htrans;
    logic                  i_hwrite;
    logic [2:0]            i_hsize;
    logic [DATA_WIDTH-1:0] i_hwdata;
    logic                  i_hready;
    logic                  o_hreadyout;
    logic                  o_hresp;
    logic [DATA_WIDTH-1:0] o_hrdata;

    modport master (
        output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hwdata, i_hready,
        input  o_hreadyout, o_hresp, o_hrdata
    );

    modport slave (
        input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hwdata, i_hready,
        output o_hreadyout, o_hresp, o_hrdata
    );
endinterface

// File: rtl/sram_byte_array.sv
// Word-organised storage with per-byte write enables, synchronous write and
// combinational read. Contents are deliberately not reset.
module sram_byte_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: IDLE -> (WAIT) -> DATA for legal transfers, ERR1 -> ERR2
// for illegal ones; a transfer accepted while closing DATA/ERR2 starts immediately.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input logic             i_clk_ahb,
    input logic             i_rstn_ahb,
    ahb_sram_slave_if.slave bus
);
    localparam int                  IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
    localparam logic [3:0]          WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;

    logic                  accept;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      mem_idx;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_rdata;

    always_comb begin
        accept   = bus.i_hsel && bus.i_hready &&
                   ((bus.i_htrans == HTRANS_NONSEQ) || (bus.i_htrans == HTRANS_SEQ));
        offset   = bus.i_haddr - BASE_ADDR;
        addr_err = (bus.i_haddr < BASE_ADDR)
                || ({1'b0, offset} >= MEM_BYTES)
                || (bus.i_hsize > HSIZE_WORD)
                || ((bus.i_hsize == HSIZE_HALF) && bus.i_haddr[0])
                || ((bus.i_hsize == HSIZE_WORD) && (bus.i_haddr[1:0] != 2'b00));
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                // IDLE, DATA and ERR2 all see a live address phase on this edge
                default: begin
                    if (accept) begin
                        addr_q  <= bus.i_haddr;
                        write_q <= bus.i_hwrite;
                        size_q  <= bus.i_hsize;
                        if (addr_err) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= WS_LOAD;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b0;
                        end else begin
                            state_q     <= ST_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 1'b0;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_idx = IDX_W'((addr_q - BASE_ADDR) >> 2);
    assign mem_we  = (state_q == ST_DATA) && write_q;
    assign mem_be  = byte_en(size_q, addr_q[1:0]);

    sram_byte_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (i_clk_ahb),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .idx_i   (mem_idx),
        .wdata_i (32'(bus.i_hwdata)),
        .rdata_o (mem_rdata)
    );

    // Combinational read path lets a read right after a write see the committed word.
    assign bus.o_hreadyout = hreadyout_q;
    assign bus.o_hresp     = hresp_q;
    assign bus.o_hrdata    = ((state_q == ST_DATA) && !write_q) ? DATA_WIDTH'(mem_rdata) : '0;
endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, 32, address bus width.
REQ-003 Parameter MEM_DEPTH, 256, number of 32-bit words; power of two.
REQ-004 Parameter BASE_ADDR, 32'h0, byte address of word 0.
REQ-005 Parameter WAIT_STATES, 0, HREADYOUT-low cycles per OKAY data phase; range 0..15.
REQ-006 i_clk_ahb  in  1  clock; one clock only.
REQ-007 i_rstn_ahb  in  1  reset; asynchronous, active-low.
REQ-008 i_hsel  in  1  slave select.
REQ-009 i_haddr  in  ADDR_WIDTH  byte address, address phase.
REQ-010 i_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 i_hwrite  in  1  1=write, 0=read.
REQ-012 i_hsize  in  3  000=byte, 001=half, 010=word.
REQ-013 i_hwdata  in  DATA_WIDTH  write data, data phase.
REQ-014 i_hready  in  1  bus-level HREADY from the interconnect mux.
REQ-015 o_hreadyout  out  1  slave ready; low extends the data phase.
REQ-016 o_hresp  out  1  0=OKAY, 1=ERROR.
REQ-017 o_hrdata  out  DATA_WIDTH  read data, data phase.

Function
REQ-018 A transfer SHALL be accepted at a rising edge with i_hsel=1, i_htrans[1]=1 and i_hready=1; i_haddr, i_hwrite and i_hsize SHALL be registered at that edge.
REQ-019 IDLE/BUSY transfers and unselected cycles SHALL produce a zero-wait OKAY response (o_hreadyout=1, o_hresp=0).
REQ-020 FSM states SHALL be IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-021 On an OKAY accept, the FSM SHALL go to WAIT with the counter loaded to WAIT_STATES-1 when WAIT_STATES>0, otherwise directly to DATA.
REQ-022 WAIT SHALL hold o_hreadyout=0 and decrement the counter; when the counter reaches 0 the FSM SHALL go to DATA.
REQ-023 DATA SHALL drive o_hreadyout=1 for exactly one cycle; a write SHALL commit at the closing edge.
REQ-024 Write byte enables SHALL be decoded from hsize and haddr[1:0] in little-endian order: byte gives 1 lane, half gives lanes {1:0} or {3:2}, word gives all 4.
REQ-025 A read SHALL drive the full word mem[idx] on o_hrdata during DATA; outside DATA o_hrdata SHALL be 0.
REQ-026 An accepted transfer SHALL be an error when haddr<BASE_ADDR, when (haddr-BASE_ADDR)>=MEM_DEPTH*4, when hsize>010, or when haddr is misaligned to hsize.
REQ-027 An error SHALL take two cycles: ERR1 drives hresp=1 and hreadyout=0; ERR2 drives hresp=1 and hreadyout=1. No wait states, no memory write.
REQ-028 A new transfer accepted on the closing edge of DATA or ERR2 SHALL start its own response next cycle with no idle bubble.
REQ-029 A write followed back-to-back by a read of the same word SHALL return the newly written data.
REQ-030 i_hwdata SHALL be sampled only in the DATA cycle.

Reset
REQ-031 Reset SHALL set the FSM to IDLE, the counter to 0, o_hreadyout=1, o_hresp=0 and o_hrdata=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer and discard any pending write; memory contents SHALL NOT be reset.

Structure
REQ-033 The HTRANS and HSIZE encodings and the FSM state enum SHALL live in the shared package ahb_pkg.
REQ-034 Storage SHALL be the sub-module sram_byte_array (MEM_DEPTH x 32, 4 byte-enables, asynchronous read, synchronous write).

Verification
REQ-035 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> hreadyout never low; read returns 0xDEADBEEF.
REQ-036 WAIT_STATES=2: word read @0x4 -> hreadyout low 2 cycles, then high with data, hresp=0.
REQ-037 Byte write 0xAA @0x21 over word 0x11223344 @0x20 -> readback 0x1122AA44.
REQ-038 Read @MEM_DEPTH*4 and half write @0x3 -> each gives ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1); memory unchanged.
REQ-039 Back-to-back NONSEQ write @0x8 then read @0x8, zero wait -> read returns the written value, no idle cycle between.
REQ-040 Reset asserted during WAIT of a write -> outputs reach reset values immediately; target word unchanged.
